// File: rtl/usb_rx_pkg.sv
// Shared constants and payload types for the USB full-speed receive front end.
package usb_rx_pkg;

    localparam int unsigned USB_CLKS_PER_BIT  = 8;
    localparam int unsigned USB_SAMPLE_PHASE  = 3;
    localparam int unsigned USB_BITS_PER_BYTE = 8;
    localparam int unsigned USB_STUFF_LIMIT   = 6;
    localparam logic        USB_IDLE_LVL      = 1'b1;

    // Registered per-bit results handed to the serial-to-parallel stage
    typedef struct packed {
        logic serial_out;
        logic shift_strobe;
        logic byte_done;
        logic stuff_err;
    } rx_bit_out_t;

    localparam rx_bit_out_t RX_BIT_OUT_RST = '{
        serial_out:   USB_IDLE_LVL,
        shift_strobe: 1'b0,
        byte_done:    1'b0,
        stuff_err:    1'b0
    };

endpackage

// File: rtl/usb_rx_bit_sampler_if.sv
// Line-side inputs and decoded-bit outputs of the receive bit sampler.
interface usb_rx_bit_sampler_if;

    logic rcving;
    logic d_plus_sync;
    logic d_edge;
    logic serial_out;
    logic shift_strobe;
    logic byte_done;
    logic stuff_err;

    modport master (
        output rcving, d_plus_sync, d_edge,
        input  serial_out, shift_strobe, byte_done, stuff_err
    );

    modport slave (
        input  rcving, d_plus_sync, d_edge,
        output serial_out, shift_strobe, byte_done, stuff_err
    );

endinterface

// File: rtl/usb_rx_bit_timer.sv
// Oversampling bit timer: free-runs while enabled, re-aligns on every line edge,
// and flags the mid-bit sample point.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE = USB_SAMPLE_PHASE
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic resync,
    output logic sample_tick_c
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);

    logic [TMR_W-1:0] bit_tmr;
    logic [TMR_W-1:0] bit_tmr_nxt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_tmr <= '0;
        end else begin
            bit_tmr <= bit_tmr_nxt;
        end
    end

    always_comb begin
        bit_tmr_nxt = bit_tmr;
        if (!en || resync) begin
            bit_tmr_nxt = '0;
        end else if (bit_tmr == TMR_W'(CLKS_PER_BIT - 1)) begin
            bit_tmr_nxt = '0;
        end else begin
            bit_tmr_nxt = bit_tmr + TMR_W'(1);
        end
    end

    // An edge landing on the sample point defers sampling to the re-aligned bit
    assign sample_tick_c = en && !resync && (bit_tmr == TMR_W'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx_bit_sampler.sv
// USB full-speed receive front end: mid-bit sampling, NRZI decode and bit unstuffing,
// producing one strobe per accepted bit and a byte boundary pulse.
module usb_rx_bit_sampler
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PHASE  = USB_SAMPLE_PHASE,
    parameter int unsigned BITS_PER_BYTE = USB_BITS_PER_BYTE,
    parameter int unsigned STUFF_LIMIT   = USB_STUFF_LIMIT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_rx_bit_sampler_if.slave  rx
);

    localparam int unsigned CNT_W  = $clog2(BITS_PER_BYTE);
    localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);

    logic              sample_tick_c;
    logic              decoded_c;
    logic              prev_lvl;
    logic              prev_lvl_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [ONES_W-1:0] ones_cnt;
    logic [ONES_W-1:0] ones_cnt_nxt;
    rx_bit_out_t       out_q;
    rx_bit_out_t       out_nxt;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .en            (rx.rcving),
        .resync        (rx.d_edge),
        .sample_tick_c (sample_tick_c)
    );

    // NRZI: no transition since the previous sample decodes as 1
    assign decoded_c = (rx.d_plus_sync == prev_lvl);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prev_lvl <= USB_IDLE_LVL;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            out_q    <= RX_BIT_OUT_RST;
        end else begin
            prev_lvl <= prev_lvl_nxt;
            bit_cnt  <= bit_cnt_nxt;
            ones_cnt <= ones_cnt_nxt;
            out_q    <= out_nxt;
        end
    end

    always_comb begin
        prev_lvl_nxt         = prev_lvl;
        bit_cnt_nxt          = bit_cnt;
        ones_cnt_nxt         = ones_cnt;
        out_nxt              = out_q;
        out_nxt.shift_strobe = 1'b0;
        out_nxt.byte_done    = 1'b0;
        out_nxt.stuff_err    = 1'b0;

        if (!rx.rcving) begin
            prev_lvl_nxt = USB_IDLE_LVL;
            bit_cnt_nxt  = '0;
            ones_cnt_nxt = '0;
        end else if (sample_tick_c) begin
            prev_lvl_nxt = rx.d_plus_sync;
            if (ones_cnt < ONES_W'(STUFF_LIMIT)) begin
                out_nxt.shift_strobe = 1'b1;
                out_nxt.serial_out   = decoded_c;
                out_nxt.byte_done    = (bit_cnt == CNT_W'(BITS_PER_BYTE - 1));
                bit_cnt_nxt          = out_nxt.byte_done ? '0 : bit_cnt + CNT_W'(1);
                ones_cnt_nxt         = decoded_c ? ones_cnt + ONES_W'(1) : '0;
            end else begin
                // Stuff-bit slot: always dropped, a 1 here is a protocol error
                out_nxt.stuff_err = decoded_c;
                ones_cnt_nxt      = '0;
            end
        end
    end

    assign rx.serial_out   = out_q.serial_out;
    assign rx.shift_strobe = out_q.shift_strobe;
    assign rx.byte_done    = out_q.byte_done;
    assign rx.stuff_err    = out_q.stuff_err;

endmodule
